// File: rtl/rx_seq_check_pkg.sv
// -----------------------------------------------------------------------------
// rx_seq_check_pkg
// Shared constants and state encodings for the RX sequence checker and its
// frame counter. The frame counter encoding is also used by the TX path.
// Build option: RX_SEQ_ERR_CNT_EN (see rx_seq_check.sv).
// -----------------------------------------------------------------------------
package rx_seq_check_pkg;

   localparam int          DATA_W           = 32;
   localparam int          FRAME_CNT_W      = 64;
   localparam logic [15:0] SEQ_INIT_DEFAULT = 16'h0001;

   // Main framing FSM: S_HOLD means one payload word is waiting in the hold
   // register for the next beat to reveal whether it is the last payload word.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } rx_state_e;

   // Frame counter FSM: S_CNT_RST keeps counters at zero while a clear
   // request is held.
   typedef enum logic {
      S_CNT_COUNT = 1'b0,
      S_CNT_RST   = 1'b1
   } cnt_state_e;

endpackage

// File: rtl/rx_seq_check_frame_cntr.sv
// -----------------------------------------------------------------------------
// frame_cntr
// Frame counter with a level-sensitive clear request. While clr_req is high
// the count is forced to zero and increments are ignored; after clr_req drops
// the counter spends one cycle leaving S_CNT_RST before counting again.
// Ports:
//   clk, srst  - clock, synchronous active-high reset
//   clr_req    - level clear request (wins over inc in the same cycle)
//   inc        - count one frame
//   count      - registered count value
//   clearing   - high while counters must be held at zero (request or
//                S_CNT_RST); lets sibling counters follow the same handshake
// -----------------------------------------------------------------------------
module frame_cntr
   import rx_seq_check_pkg::*;
#(
   parameter int CNT_W = FRAME_CNT_W
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             clr_req,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             clearing
);

   cnt_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_CNT_COUNT: begin
            if (clr_req) begin
               cnt_d   = '0;
               state_d = S_CNT_RST;
            end else if (inc) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CNT_RST: begin
            cnt_d = '0;
            if (!clr_req) begin
               state_d = S_CNT_COUNT;
            end
         end
         default: state_d = S_CNT_COUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= S_CNT_COUNT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign count    = cnt_q;
   assign clearing = clr_req | (state_q == S_CNT_RST);

endmodule

// File: rtl/rx_seq_check.sv
// -----------------------------------------------------------------------------
// rx_seq_check
// Receive-side sequence-number stripper/checker. Each frame ends with a word
// whose low SEQ_W bits are a sequence number. In strip mode that word is
// removed and tlast moves onto the last payload word; in pass mode beats are
// forwarded unchanged. Sequence continuity is checked on every tlast beat.
// Ports:
//   m_axis_aclk / m_axis_areset - clock, synchronous active-high reset
//   s_axis_*      - input stream (no ready; cannot be stalled)
//   m_axis_*      - output stream (no ready; consumer accepts every beat)
//   ctrl_strip_seq_en - 1 strip / 0 pass, sampled on the first beat of a frame
//   ctrl_rst_cntr_in  - level request to clear frame and error counters
//   slv_cntr_in   - received frame count (runts included)
//   slv_seq_err   - saturating count of sequence discontinuities
//   slv_seq_last  - last received sequence number
//   seq_err_pulse - one-cycle pulse per discontinuity
// Build option: define RX_SEQ_ERR_CNT_EN to implement the sequence comparison,
// slv_seq_err and seq_err_pulse; otherwise both outputs are tied to zero.
// -----------------------------------------------------------------------------
module rx_seq_check
   import rx_seq_check_pkg::*;
#(
   parameter int               SEQ_W     = 16,
   parameter logic [SEQ_W-1:0] SEQ_INIT  = SEQ_W'(SEQ_INIT_DEFAULT),
   parameter int               ERR_CNT_W = 32
) (
   input  logic                   m_axis_aclk,
   input  logic                   m_axis_areset,
   input  logic                   s_axis_tvalid,
   input  logic [DATA_W-1:0]      s_axis_tdata,
   input  logic                   s_axis_tlast,
   output logic                   m_axis_tvalid,
   output logic [DATA_W-1:0]      m_axis_tdata,
   output logic                   m_axis_tlast,
   input  logic                   ctrl_strip_seq_en,
   input  logic                   ctrl_rst_cntr_in,
   output logic [FRAME_CNT_W-1:0] slv_cntr_in,
   output logic [ERR_CNT_W-1:0]   slv_seq_err,
   output logic [SEQ_W-1:0]       slv_seq_last,
   output logic                   seq_err_pulse
);

   rx_state_e         state_q, state_d;
   logic              strip_q, strip_d;          // mode latched for the current frame
   logic              mid_frame_q, mid_frame_d;  // a frame has started but not ended
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              m_last_q, m_last_d;
   logic [SEQ_W-1:0]  seq_last_q, seq_last_d;
   logic [SEQ_W-1:0]  rx_seq;
   logic              frame_end;
   logic              strip_now;
   logic              cnt_clearing;

   assign rx_seq    = s_axis_tdata[SEQ_W-1:0];
   assign frame_end = s_axis_tvalid & s_axis_tlast;
   // Pass mode never leaves S_IDLE, so the frame start is tracked separately
   // from the FSM state to keep the mode fixed for a whole frame.
   assign strip_now = mid_frame_q ? strip_q : ctrl_strip_seq_en;

   always_comb begin
      state_d     = state_q;
      strip_d     = strip_q;
      mid_frame_d = mid_frame_q;
      hold_d      = hold_q;
      m_valid_d   = 1'b0;
      m_data_d    = m_data_q;
      m_last_d    = 1'b0;
      seq_last_d  = frame_end ? rx_seq : seq_last_q;
      if (s_axis_tvalid) begin
         strip_d     = strip_now;
         mid_frame_d = ~s_axis_tlast;
         if (strip_now) begin
            if (state_q == S_IDLE) begin
               // A last beat here is a runt: nothing to emit.
               if (!s_axis_tlast) begin
                  hold_d  = s_axis_tdata;
                  state_d = S_HOLD;
               end
            end else begin
               m_valid_d = 1'b1;
               m_data_d  = hold_q;
               m_last_d  = s_axis_tlast;
               if (s_axis_tlast) begin
                  state_d = S_IDLE;
               end else begin
                  hold_d = s_axis_tdata;
               end
            end
         end else begin
            m_valid_d = 1'b1;
            m_data_d  = s_axis_tdata;
            m_last_d  = s_axis_tlast;
         end
      end
   end

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         state_q     <= S_IDLE;
         strip_q     <= 1'b1;
         mid_frame_q <= 1'b0;
         hold_q      <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_last_q    <= 1'b0;
         seq_last_q  <= '0;
      end else begin
         state_q     <= state_d;
         strip_q     <= strip_d;
         mid_frame_q <= mid_frame_d;
         hold_q      <= hold_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_last_q    <= m_last_d;
         seq_last_q  <= seq_last_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tlast  = m_last_q;
   assign slv_seq_last  = seq_last_q;

   frame_cntr #(
      .CNT_W (FRAME_CNT_W)
   ) u_frame_cntr (
      .clk      (m_axis_aclk),
      .srst     (m_axis_areset),
      .clr_req  (ctrl_rst_cntr_in),
      .inc      (frame_end),
      .count    (slv_cntr_in),
      .clearing (cnt_clearing)
   );

`ifdef RX_SEQ_ERR_CNT_EN
   logic [SEQ_W-1:0]     expected_q, expected_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 err_pulse_q, err_pulse_d;
   logic                 seq_mismatch;

   assign seq_mismatch = frame_end & (rx_seq != expected_q);

   always_comb begin
      // Always resync to the received number so one gap counts one error.
      expected_d  = frame_end ? rx_seq + SEQ_W'(1) : expected_q;
      err_pulse_d = seq_mismatch;
      err_cnt_d   = err_cnt_q;
      if (cnt_clearing) begin
         err_cnt_d = '0;
      end else if (seq_mismatch && !(&err_cnt_q)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         expected_q  <= SEQ_INIT;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         expected_q  <= expected_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign slv_seq_err   = err_cnt_q;
   assign seq_err_pulse = err_pulse_q;
`else
   localparam logic [SEQ_W-1:0] unused_seq_init = SEQ_INIT;
   logic unused_cnt_clearing;

   assign unused_cnt_clearing = cnt_clearing;
   assign slv_seq_err         = '0;
   assign seq_err_pulse       = 1'b0;
`endif

endmodule

// File: tb/tb_rx_seq_check.sv
// -----------------------------------------------------------------------------
// tb_rx_seq_check
// Self-checking bench for rx_seq_check. A frame-level reference model (queue of
// payload words per frame, integer counters) predicts every output for every
// cycle; directed scenarios are followed by randomized frames.
// -----------------------------------------------------------------------------
module tb_rx_seq_check;

`ifdef RX_SEQ_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        srst;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_last;
   logic        strip_en;
   logic        rst_req;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_last;
   logic [63:0] cntr;
   logic [31:0] seq_err;
   logic [15:0] seq_last;
   logic        pulse;

   always #5 clk = ~clk;

   rx_seq_check dut (
      .m_axis_aclk       (clk),
      .m_axis_areset     (srst),
      .s_axis_tvalid     (s_valid),
      .s_axis_tdata      (s_data),
      .s_axis_tlast      (s_last),
      .m_axis_tvalid     (m_valid),
      .m_axis_tdata      (m_data),
      .m_axis_tlast      (m_last),
      .ctrl_strip_seq_en (strip_en),
      .ctrl_rst_cntr_in  (rst_req),
      .slv_cntr_in       (cntr),
      .slv_seq_err       (seq_err),
      .slv_seq_last      (seq_last),
      .seq_err_pulse     (pulse)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_buf[$];
   bit          m_strip    = 1'b1;
   bit          m_in_frame = 1'b0;
   bit          m_cnt_rst  = 1'b0;
   logic [15:0] m_exp      = 16'h0001;
   logic [15:0] m_seq_last = 16'h0000;
   logic [63:0] m_cnt      = 64'd0;
   logic [31:0] m_err      = 32'd0;
   bit          e_valid, e_last, e_pulse;
   logic [31:0] e_data     = 32'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_buf.delete();
      m_strip    = 1'b1;
      m_in_frame = 1'b0;
      m_cnt_rst  = 1'b0;
      m_exp      = 16'h0001;
      m_seq_last = 16'h0000;
      m_cnt      = 64'd0;
      m_err      = 32'd0;
      e_data     = 32'd0;
   endtask

   // One clock cycle: drive a beat (or idle), predict, then check all outputs.
   task automatic step(input bit v, input logic [31:0] d, input bit l);
      bit frame;
      bit mism;
      s_valid = v;
      s_data  = d;
      s_last  = l;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_pulse = 1'b0;
      frame   = 1'b0;
      mism    = 1'b0;
      if (srst) begin
         model_reset();
      end else begin
         if (v) begin
            if (!m_in_frame) m_strip = strip_en;
            if (m_strip) begin
               // Stripped output lags by one beat: the previous word of the
               // frame comes out, flagged last when this beat is the seq word.
               if (m_buf.size() > 0) begin
                  e_valid = 1'b1;
                  e_data  = m_buf[$];
                  e_last  = l;
               end
               m_buf.push_back(d);
            end else begin
               e_valid = 1'b1;
               e_data  = d;
               e_last  = l;
            end
            m_in_frame = !l;
            if (l) begin
               frame = 1'b1;
               m_buf.delete();
               mism       = ERR_EN && (d[15:0] != m_exp);
               m_exp      = d[15:0] + 16'd1;
               m_seq_last = d[15:0];
            end
         end
         e_pulse = mism;
         if (rst_req) begin
            m_cnt     = 64'd0;
            m_err     = 32'd0;
            m_cnt_rst = 1'b1;
         end else if (m_cnt_rst) begin
            m_cnt_rst = 1'b0;
         end else begin
            if (frame) m_cnt++;
            if (mism && m_err != 32'hFFFF_FFFF) m_err++;
         end
      end
      @(posedge clk);
      #1;
      chk("tvalid", m_valid, e_valid);
      chk("tlast", m_last, e_last);
      if (e_valid || srst) chk("tdata", m_data, e_data);
      chk("seq_err_pulse", pulse, e_pulse);
      chk("slv_cntr_in", cntr, m_cnt);
      chk("slv_seq_err", seq_err, m_err);
      chk("slv_seq_last", seq_last, m_seq_last);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // nwords payload words (0 = runt), then the sequence word, then idle gap.
   task automatic send_frame(input int nwords, input logic [15:0] seq, input int gap);
      logic [15:0] hi;
      for (int i = 0; i < nwords; i++) step(1'b1, $urandom, 1'b0);
      hi = 16'($urandom);
      step(1'b1, {hi, seq}, 1'b1);
      for (int i = 0; i < gap; i++) step(1'b0, 32'd0, 1'b0);
   endtask

   initial begin
      int          nw;
      logic [15:0] sq;
      srst     = 1'b1;
      s_valid  = 1'b0;
      s_data   = 32'd0;
      s_last   = 1'b0;
      strip_en = 1'b1;
      rst_req  = 1'b0;

      // Reset state
      step(1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      srst = 1'b0;
      step(1'b0, 32'd0, 1'b0);

      // Strip mode D0,D1,D2,seq=0001
      step(1'b1, 32'hA000_0000, 1'b0);
      step(1'b1, 32'hA000_0001, 1'b0);
      step(1'b1, 32'hA000_0002, 1'b0);
      step(1'b1, 32'h0000_0001, 1'b1);
      chk("t1_last_word", m_data, 32'hA000_0002);
      chk("t1_cntr", cntr, 64'd1);
      chk("t1_seq_last", seq_last, 64'h0001);
      step(1'b0, 32'd0, 1'b0);

      // Sequence gap 0002 -> 0004, then 0005
      send_frame(2, 16'h0002, 0);
      send_frame(1, 16'h0004, 1);
      chk("t2_err_cnt", seq_err, ERR_EN ? 64'd1 : 64'd0);
      send_frame(2, 16'h0005, 0);

      // Wrap FFFF -> 0000
      send_frame(1, 16'hFFFF, 0);
      send_frame(1, 16'h0000, 0);
      chk("wrap_no_err", pulse, 64'd0);
      chk("wrap_seq_last", seq_last, 64'h0000);

      // Pass mode D0,seq=0001
      strip_en = 1'b0;
      step(1'b1, 32'hB000_0000, 1'b0);
      step(1'b1, 32'h0000_0001, 1'b1);
      chk("pass_seq_word", m_data, 32'h0000_0001);
      // Toggle to strip mid pass frame: frame stays pass
      step(1'b1, 32'hC000_0000, 1'b0);
      strip_en = 1'b1;
      step(1'b1, 32'hC000_0001, 1'b0);
      step(1'b1, 32'h0000_0002, 1'b1);
      send_frame(2, 16'h0003, 0);
      // Toggle to pass mid strip frame: frame stays strip
      step(1'b1, 32'hD000_0000, 1'b0);
      strip_en = 1'b0;
      step(1'b1, 32'hD000_0001, 1'b0);
      step(1'b1, 32'h0000_0004, 1'b1);
      send_frame(1, 16'h0005, 1);
      strip_en = 1'b1;

      // Runt, then counter clear held 5 cycles over 2 frames
      send_frame(0, 16'h0006, 1);
      rst_req = 1'b1;
      step(1'b1, 32'hE000_0000, 1'b0);
      step(1'b1, 32'h0000_0007, 1'b1);
      step(1'b1, 32'hE000_0001, 1'b0);
      step(1'b1, 32'h0000_0008, 1'b1);
      step(1'b0, 32'd0, 1'b0);
      chk("clr_cntr", cntr, 64'd0);
      rst_req = 1'b0;
      step(1'b0, 32'd0, 1'b0);
      send_frame(1, 16'h0009, 0);
      chk("cnt_resume", cntr, 64'd1);

      // Reset while a word is held
      step(1'b1, 32'hF000_0000, 1'b0);
      step(1'b1, 32'hF000_0001, 1'b0);
      srst = 1'b1;
      step(1'b1, 32'hF000_0002, 1'b0);
      srst = 1'b0;
      send_frame(1, 16'h0001, 0);
      chk("rst_no_err", pulse, 64'd0);

      // Randomized frames
      for (int f = 0; f < 60; f++) begin
         strip_en = 1'($urandom_range(0, 1));
         nw       = $urandom_range(0, 4);
         sq       = ($urandom_range(0, 5) == 0) ? 16'($urandom) : m_exp;
         send_frame(nw, sq, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_seq_check.md
# rx_seq_check

Receive-side companion to the transmit sequence-number inserter. It sits between the Aurora RX user interface and the NovaCor-facing AXI-Stream consumer. It consumes frames whose final 32-bit word carries a 16-bit sequence number, strips that word, and moves `tlast` onto the last payload word. It also checks sequence continuity and keeps frame and error counters for the slave register file.

## Interface
Parameters:
- `SEQ_W`, 16, sequence number width; the sequence number is taken from `s_axis_tdata[SEQ_W-1:0]`.
- `SEQ_INIT`, 16'h0001, first expected sequence number after reset.
- `ERR_CNT_W`, 32, width of the sequence error counter.

Ports:
- `m_axis_aclk`  in  1  single clock for the whole block.
- `m_axis_areset`  in  1  reset; synchronous, active-high.
- `s_axis_tvalid`  in  1  beat valid from Aurora RX. There is no `s_axis_tready`: the source cannot be stalled.
- `s_axis_tdata`  in  32  beat data.
- `s_axis_tlast`  in  1  marks the sequence word.
- `m_axis_tvalid`  out  1  output beat valid. There is no `m_axis_tready`: the consumer must accept every beat.
- `m_axis_tdata`  out  32  output beat data.
- `m_axis_tlast`  out  1  last beat of the output frame.
- `ctrl_strip_seq_en`  in  1  1 = strip the sequence word; 0 = pass it through.
- `ctrl_rst_cntr_in`  in  1  level request to clear the counters.
- `slv_cntr_in`  out  64  number of received frames.
- `slv_seq_err`  out  ERR_CNT_W  number of sequence discontinuities.
- `slv_seq_last`  out  SEQ_W  last received sequence number.
- `seq_err_pulse`  out  1  one-cycle pulse per discontinuity.

## Operation
- Main FSM states:
  - S_IDLE: no word held; frame boundary.
  - S_HOLD: one payload word held in the hold register.
- Strip mode, S_IDLE:
  - Non-last beat: load the hold register, go to S_HOLD, no output.
  - Last beat: runt frame. Check its sequence number and count the frame; no output.
- Strip mode, S_HOLD:
  - Non-last beat: emit the held word with `tlast`=0, load the new word, stay in S_HOLD.
  - Last beat: emit the held word with `tlast`=1, check the sequence number, go to S_IDLE.
- Pass mode: every beat is registered to the output unchanged, including `tlast`. The FSM stays in S_IDLE and the `tlast` beat is still checked.
- Mode latch: `ctrl_strip_seq_en` is sampled only on the first beat of a frame, i.e. a valid beat in S_IDLE. Changes mid-frame take effect on the next frame.
- Sequence check on every `tlast` beat; `rx` = `tdata[SEQ_W-1:0]`:
  - If `rx != expected`: pulse `seq_err_pulse` and increment `slv_seq_err`, which saturates at all-ones.
  - In all cases `expected <= rx + 1` (resync), modulo 2^SEQ_W, so 16'hFFFF is followed by 16'h0000.
  - `slv_seq_last <= rx`.
- Frame counter:
  - `slv_cntr_in` increments on every `tlast` beat, runts included.
  - Counter FSM states S_CNT_COUNT and S_CNT_RST. When `ctrl_rst_cntr_in`=1, clear `slv_cntr_in` and `slv_seq_err` and enter S_CNT_RST.
  - S_CNT_RST holds the counters at 0 and ignores frames until `ctrl_rst_cntr_in`=0, then returns to S_CNT_COUNT.
  - If a clear and a frame end land in the same cycle, the clear wins.
- `expected` is not affected by a counter clear.

## Timing
- All outputs are registered.
- Reset values:
  - `m_axis_tvalid` 0, `m_axis_tlast` 0, `m_axis_tdata` 0.
  - `slv_cntr_in` 0, `slv_seq_err` 0, `slv_seq_last` 0, `seq_err_pulse` 0.
  - `expected` = SEQ_INIT, FSM in S_IDLE, counter FSM in S_CNT_COUNT, mode latch = strip.
- Strip mode latency: payload word k appears one cycle after input beat k+1. The last payload word appears the cycle after the sequence word.
- Pass mode latency: 1 cycle.
- `seq_err_pulse`, `slv_seq_err` and `slv_seq_last` update the cycle after the `tlast` beat.
- Output valid is a single-cycle pulse per beat. Back-to-back input beats give back-to-back output beats.
- Reset mid-frame: the held word is discarded and `m_axis_tvalid`=0 on the cycle after reset is asserted. No partial `tlast` is emitted.

## Configuration
- `RX_SEQ_ERR_CNT_EN` defined: sequence comparison, `slv_seq_err` and `seq_err_pulse` are implemented as described above.
- Not defined:
  - Comparison logic and error counter are omitted.
  - `slv_seq_err` is tied to 0 and `seq_err_pulse` to 0.
  - `slv_seq_last` and stripping are still implemented.

## Structure
- State encodings (S_IDLE/S_HOLD, S_CNT_COUNT/S_CNT_RST) and the SEQ_INIT default go in the shared `defines.vh`, alongside the TX-side constants.
- Sub-module `frame_cntr`: 64-bit frame counter with the reset-request handshake. It is shared with the TX path, which has the same counter behaviour.

## Test plan
- Strip mode, frame D0,D1,D2,seq=0001: output D0,D1,D2 with `tlast` on D2. `slv_cntr_in`=1, `slv_seq_err`=0, `slv_seq_last`=0001.
- Frames with seq 0001, 0002, 0004: exactly one `seq_err_pulse`, after the third frame. `slv_seq_err`=1. A following frame with seq 0005 gives no error.
- Wrap: seq FFFF followed by 0000: no error.
- Pass mode, frame D0,seq=0001: output D0, then 00000001 with `tlast`. Toggle `ctrl_strip_seq_en` mid-frame: the current frame is unchanged and the next frame uses the new mode.
- Runt frame (single `tlast` beat, seq 0001): no output, `slv_cntr_in`=1. Hold `ctrl_rst_cntr_in` high for 5 cycles while 2 frames arrive: counters read 0; counting resumes after deassert.
- Assert reset while in S_HOLD: no output beat. The next frame with seq 0001 gives no error.
